pc_ras_unit: RTL and testbench

- Parametrised program-counter block, successor to the 8-bit branch-only PC.
- Adds a configurable address width, a signed branch offset, absolute jump, stall, and call/return through a circular return-address stack (RAS) of configurable depth.
- Sits at the head of the fetch path and drives the instruction-memory address each cycle.

---
 rtl/pc_ras_unit.sv | 139 +++++++++++++
 tb/tb_pc_ras_unit.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// pc_ras_unit
//   Program counter at the head of the fetch path. Every cycle it chooses one
//   next PC from these sources: stall (hold), ret (pop), call (push and jump),
//   jump, relative branch, or sequential increment. Call and ret use a
//   circular return-address stack (RAS).
//
// Ports
//   CLK            rising-edge clock
//   RESET          synchronous reset, active low
//   stall          hold the PC and the RAS; the flags read 0
//   branch         address <= address + 1 + sext(branch_offset)
//   branch_offset  two's-complement offset, OFF_W bits
//   jump           address <= jump_target
//   call           push address+1, then address <= jump_target
//   ret            pop the RAS into address
//   jump_target    absolute target for jump and call
//   address        registered PC
//   ras_count      number of valid RAS entries (0..DEPTH)
//   ras_empty      ras_count == 0
//   ras_full       ras_count == DEPTH
//   ras_overflow   one-cycle pulse: a call was made while the RAS was full
//   ras_underflow  one-cycle pulse: a ret was made while the RAS was empty
module pc_ras_unit #(
  parameter int                ADDR_W     = 8,
  parameter int                OFF_W      = 8,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       stall,
  input  logic                       branch,
  input  logic [OFF_W-1:0]           branch_offset,
  input  logic                       jump,
  input  logic                       call,
  input  logic                       ret,
  input  logic [ADDR_W-1:0]          jump_target,
  output logic [ADDR_W-1:0]          address,
  output logic [$clog2(DEPTH):0]     ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_overflow,
  output logic                       ras_underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] r_addr;
  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_ptr;
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_ras [DEPTH];

  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_sext;
  logic [PW-1:0]     w_ptr_dec;
  logic              w_empty;
  logic              w_full;

  logic [ADDR_W-1:0] w_addr_nxt;
  logic [CW-1:0]     w_count_nxt;
  logic [PW-1:0]     w_ptr_nxt;
  logic              w_push;
  logic              w_ovf_nxt;
  logic              w_unf_nxt;

  assign w_inc     = r_addr + ADDR_W'(1);
  // A size cast of a signed value sign-extends. This also works when OFF_W == ADDR_W.
  assign w_sext    = ADDR_W'($signed(branch_offset));
  assign w_ptr_dec = r_ptr - PW'(1);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));

  always_comb begin
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_ptr_nxt   = r_ptr;
    w_push      = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_unf_nxt   = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (w_empty) begin
          w_addr_nxt = w_inc;
          w_unf_nxt  = 1'b1;
        end else begin
          w_addr_nxt  = r_ras[w_ptr_dec];
          w_ptr_nxt   = w_ptr_dec;
          w_count_nxt = r_count - CW'(1);
        end
      end else if (call) begin
        // When the RAS is full, ptr points at the oldest entry. The push
        // overwrites that entry, so the DEPTH newest addresses stay in LIFO order.
        w_push     = 1'b1;
        w_addr_nxt = jump_target;
        w_ptr_nxt  = r_ptr + PW'(1);
        if (w_full) w_ovf_nxt   = 1'b1;
        else        w_count_nxt = r_count + CW'(1);
      end else if (jump) begin
        w_addr_nxt = jump_target;
      end else if (branch) begin
        w_addr_nxt = w_inc + w_sext;
      end else begin
        w_addr_nxt = w_inc;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_addr  <= RESET_ADDR;
      r_count <= '0;
      r_ptr   <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      r_ptr   <= w_ptr_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  // The stack storage has no reset: its contents do not matter while the count is 0.
  always_ff @(posedge CLK) begin
    if (RESET && w_push) r_ras[r_ptr] <= w_inc;
  end

  assign address       = r_addr;
  assign ras_count     = r_count;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Bench for pc_ras_unit with ADDR_W=8, OFF_W=8, DEPTH=4 and RESET_ADDR=0.
// The model keeps the return addresses in a queue. A call appends to the back
// and drops the front entry when the queue holds more than DEPTH entries. A ret
// takes from the back. After every edge a compare process checks all outputs
// against the model. Directed sequences also pin literal values.
module tb_pc_ras_unit;

  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       stall = 1'b0, branch = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
  logic [7:0] branch_offset = '0;
  logic [7:0] jump_target = '0;
  logic [7:0] address;
  logic [2:0] ras_count;
  logic       ras_empty, ras_full, ras_overflow, ras_underflow;

  int n_vec = 0;
  int n_bad = 0;

  pc_ras_unit #(.ADDR_W(8), .OFF_W(8), .DEPTH(DEPTH), .RESET_ADDR(8'h00)) dut (
    .CLK(CLK), .RESET(RESET), .stall(stall), .branch(branch),
    .branch_offset(branch_offset), .jump(jump), .call(call), .ret(ret),
    .jump_target(jump_target), .address(address), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model
  logic [7:0] m_addr;
  logic [7:0] m_q[$];
  logic       m_ovf, m_unf;
  bit         m_valid = 0;

  always @(posedge CLK) begin
    if (!RESET) begin
      m_addr = 8'h00; m_q.delete(); m_ovf = 0; m_unf = 0; m_valid = 1;
    end else if (m_valid) begin
      m_ovf = 0; m_unf = 0;
      if (stall) begin
      end else if (ret) begin
        if (m_q.size() == 0) begin m_addr = 8'(m_addr + 1); m_unf = 1; end
        else m_addr = m_q.pop_back();
      end else if (call) begin
        m_q.push_back(8'(m_addr + 1));
        if (m_q.size() > DEPTH) begin void'(m_q.pop_front()); m_ovf = 1; end
        m_addr = jump_target;
      end else if (jump) begin
        m_addr = jump_target;
      end else if (branch) begin
        m_addr = 8'(int'(m_addr) + 1 + int'($signed(branch_offset)));
      end else begin
        m_addr = 8'(m_addr + 1);
      end
    end
    #1;
    if (m_valid) begin
      chk("address",   address,       m_addr);
      chk("count",     ras_count,     m_q.size());
      chk("empty",     ras_empty,     m_q.size() == 0);
      chk("full",      ras_full,      m_q.size() == DEPTH);
      chk("overflow",  ras_overflow,  m_ovf);
      chk("underflow", ras_underflow, m_unf);
    end
  end

  // Drive one cycle of inputs, then wait until the compare process has sampled.
  task automatic cyc(input logic rst_n, input logic st, input logic br, input logic [7:0] off,
                     input logic jp, input logic cl, input logic rt, input logic [7:0] tgt);
    RESET = rst_n; stall = st; branch = br; branch_offset = off;
    jump = jp; call = cl; ret = rt; jump_target = tgt;
    @(posedge CLK); #2;
  endtask

  task automatic idle();  cyc(1, 0, 0, 8'h00, 0, 0, 0, 8'h00); endtask
  task automatic jmp(input logic [7:0] t); cyc(1, 0, 0, 8'h00, 1, 0, 0, t); endtask
  task automatic cll(input logic [7:0] t); cyc(1, 0, 0, 8'h00, 0, 1, 0, t); endtask
  task automatic rtn(); cyc(1, 0, 0, 8'h00, 0, 0, 1, 8'h00); endtask

  initial begin
    // 1. Reset, then increment
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_rst_addr", address, 8'h00);
    chk("t1_rst_empty", ras_empty, 1'b1);
    idle(); chk("t1_inc1", address, 8'h01);
    idle(); chk("t1_inc2", address, 8'h02);
    idle(); chk("t1_inc3", address, 8'h03);
    chk("t1_empty", ras_empty, 1'b1);
    // 2. Branch, wrap and stall
    cyc(1, 0, 1, 8'hFC, 0, 0, 0, 0); chk("t2_branch_neg", address, 8'h00);
    jmp(8'hFF); chk("t2_jmp_ff", address, 8'hFF);
    idle(); chk("t2_wrap", address, 8'h00);
    cyc(1, 1, 1, 8'h10, 0, 0, 0, 0); chk("t2_stall", address, 8'h00);
    chk("t2_stall_flags", {ras_overflow, ras_underflow}, 2'b00);
    // 3. Nested call and return
    jmp(8'h05);
    cll(8'h40); chk("t3_call1", address, 8'h40); chk("t3_cnt1", ras_count, 3'd1);
    cll(8'h80); chk("t3_call2", address, 8'h80); chk("t3_cnt2", ras_count, 3'd2);
    rtn(); chk("t3_ret1", address, 8'h41);
    rtn(); chk("t3_ret2", address, 8'h06); chk("t3_empty", ras_empty, 1'b1);
    // 4. RAS overflow
    jmp(8'd10);
    for (int i = 1; i <= 5; i++) begin
      cll(8'(10 * (i + 1)));
      chk("t4_ovf_pulse", ras_overflow, (i == 5));
    end
    chk("t4_cnt", ras_count, 3'd4); chk("t4_full", ras_full, 1'b1);
    rtn(); chk("t4_r51", address, 8'd51);
    rtn(); chk("t4_r41", address, 8'd41);
    rtn(); chk("t4_r31", address, 8'd31);
    rtn(); chk("t4_r21", address, 8'd21);
    rtn(); chk("t4_unf", ras_underflow, 1'b1); chk("t4_unf_addr", address, 8'd22);
    idle(); chk("t4_unf_clear", ras_underflow, 1'b0);
    // 5. Priority
    jmp(8'h32); cll(8'h70);
    cyc(1, 0, 1, 8'h05, 0, 1, 1, 8'h90);
    chk("t5_ret_wins", address, 8'h33); chk("t5_cnt", ras_count, 3'd0);
    cyc(1, 0, 1, 8'h05, 1, 0, 0, 8'h99); chk("t5_jump_wins", address, 8'h99);
    // 6. Reset during a call with the RAS full
    for (int i = 0; i < 4; i++) cll(8'(8'h20 + i));
    chk("t6_full", ras_full, 1'b1);
    cyc(0, 0, 0, 0, 0, 1, 0, 8'h77);
    chk("t6_addr", address, 8'h00); chk("t6_cnt", ras_count, 3'd0);
    chk("t6_ovf", ras_overflow, 1'b0);
    // Random traffic, checked against the model by the compare process
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(99) >= 2, $urandom_range(99) < 10, $urandom_range(1),
          8'($urandom), $urandom_range(99) < 20, $urandom_range(99) < 30,
          $urandom_range(99) < 30, 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
